// File: rtl/arbi_requester.sv
// Arbiter-side requester: queues words in a small FIFO and presents the head word
// with a registered req until the arbiter grants it; flags overflow and starvation.
module arbi_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                       clk,
  input  logic                       rst_in,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       req,
  output logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       grant,
  output logic                       overflow,
  output logic                       starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]           rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [CW-1:0]           count_next;
  logic [WW-1:0]           wait_cnt, wait_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    push, pop, drop;

  assign req = (state == REQ);

  // Transfer decode, occupancy/pointer update and FSM next state
  always_comb begin
    pop         = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    count_next  = count;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    state_next  = state;

    pop  = req & grant;
    push = wr_en & (~full | pop);
    drop = wr_en & full & ~pop;
    count_next = count + CW'(push) - CW'(pop);
    if (pop) begin
      rd_ptr_next = rd_ptr + AW'(1);
    end else begin
      rd_ptr_next = rd_ptr;
    end
    if (push) begin
      wr_ptr_next = wr_ptr + AW'(1);
    end else begin
      wr_ptr_next = wr_ptr;
    end

    case (state)
      IDLE: begin
        if (push) begin
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (pop && !push && (count == CW'(1))) begin
          state_next = IDLE;
        end else begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next head word; a push into an empty (or just-emptied) queue bypasses the array
  always_comb begin
    data_next = {DATA_WIDTH{1'b0}};
    if (count_next == CW'(0)) begin
      data_next = {DATA_WIDTH{1'b0}};
    end else if (push && ((count == CW'(0)) || ((count == CW'(1)) && pop))) begin
      data_next = wr_data;
    end else begin
      data_next = mem[rd_ptr_next];
    end
  end

  // Starvation counter: counts ungranted request cycles, saturating
  always_comb begin
    wait_next = wait_cnt;
    if ((state == IDLE) || pop) begin
      wait_next = {WW{1'b0}};
    end else if (!grant && (wait_cnt < WW'(MAX_WAIT))) begin
      wait_next = wait_cnt + WW'(1);
    end else begin
      wait_next = wait_cnt;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      rd_ptr   <= {AW{1'b0}};
      wr_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      full     <= 1'b0;
      data_out <= {DATA_WIDTH{1'b0}};
      overflow <= 1'b0;
      wait_cnt <= {WW{1'b0}};
      starve   <= 1'b0;
    end else begin
      state    <= state_next;
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      count    <= count_next;
      full     <= (count_next == CW'(DEPTH));
      data_out <= data_next;
      overflow <= overflow | drop;
      wait_cnt <= wait_next;
      starve   <= (wait_next == WW'(MAX_WAIT));
    end
  end

  // Storage array; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_arbi_requester.sv
// Randomized and directed bench for arbi_requester against a queue-based reference model.
module tb_arbi_requester;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_in, wr_en, grant;
  logic [DW-1:0] wr_data, data_out;
  logic          full, req, overflow, starve;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  int            m_wait;

  arbi_requester #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_in(rst_in), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .req(req), .data_out(data_out),
    .grant(grant), .overflow(overflow), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_wait = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs currently driven
  task automatic model_edge();
    bit mreq, pop, push;
    mreq = (mq.size() != 0);
    pop  = mreq && grant;
    push = wr_en && ((mq.size() < DEPTH) || pop);
    if (wr_en && !push) m_ovf = 1'b1;
    if (pop || !mreq) m_wait = 0;
    else if (!grant && m_wait < MAXW) m_wait++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(wr_data);
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".req"},      64'(req),      64'(mq.size() != 0));
    chk({tag, ".data"},     64'(data_out), 64'(exp_data));
    chk({tag, ".count"},    64'(count),    64'(mq.size()));
    chk({tag, ".full"},     64'(full),     64'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".starve"},   64'(starve),   64'(m_wait == MAXW));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int wprob, gprob;
    rst_in = 1'b0; wr_en = 1'b0; grant = 1'b0; wr_data = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_in = 1'b1;

    // single push, no grant: request rises and word is held
    wr_en = 1'b1; wr_data = 32'hA5A5_A5A5;
    tick("push1");
    chk("push1_data_const", 64'(data_out), 64'h0000_0000_A5A5_A5A5);
    wr_en = 1'b0;
    repeat (3) tick("hold");
    grant = 1'b1;
    tick("drain1");
    grant = 1'b0;

    // three words then back-to-back transfers
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h1000_0000 + 32'(i);
      tick("push3");
    end
    wr_en = 1'b0; grant = 1'b1;
    tick("xfer0");
    chk("xfer0_head_const", 64'(data_out), 64'h0000_0000_1000_0001);
    tick("xfer1");
    tick("xfer2");
    chk("xfer_end_req", 64'(req), 64'd0);
    chk("xfer_end_count", 64'(count), 64'd0);
    grant = 1'b0;

    // full queue with simultaneous push and pop
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'h2000_0000 + 32'(i);
      tick("fill");
    end
    wr_data = 32'h2000_00FF; grant = 1'b1;
    tick("full_pp");
    chk("full_pp_count", 64'(count), 64'd4);
    chk("full_pp_ovf", 64'(overflow), 64'd0);
    wr_en = 1'b0;
    repeat (4) tick("full_drain");
    grant = 1'b0;

    // overflow: five pushes into a four-deep queue
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 32'h3000_0000 + 32'(i);
      tick("ovf_push");
    end
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    wr_en = 1'b0; grant = 1'b1;
    repeat (5) tick("ovf_drain");
    grant = 1'b0;

    // starvation after MAX_WAIT ungranted cycles
    wr_en = 1'b1; wr_data = 32'h4444_4444;
    tick("st_push");
    wr_en = 1'b0;
    repeat (MAXW - 1) tick("st_wait");
    chk("st_pre", 64'(starve), 64'd0);
    tick("st_wait");
    chk("st_set", 64'(starve), 64'd1);
    grant = 1'b1;
    tick("st_grant");
    chk("st_clear", 64'(starve), 64'd0);
    grant = 1'b0;

    // asynchronous reset with words queued
    wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data = 32'h5000_0000 + 32'(i);
      tick("rq_push");
    end
    wr_en = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    chk("arst_req", 64'(req), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    check_all("arst");
    #2;
    rst_in = 1'b1;
    grant = 1'b1;
    repeat (3) tick("post_rst");
    chk("post_rst_req", 64'(req), 64'd0);
    grant = 1'b0;

    // randomized phases with varying push/grant pressure
    wprob = 50; gprob = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) begin
        wprob = $urandom_range(0, 100);
        gprob = $urandom_range(0, 100);
      end
      wr_en   = ($urandom_range(0, 99) < wprob);
      grant   = ($urandom_range(0, 99) < gprob);
      wr_data = $urandom;
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbi_requester.md
ARBI_REQUESTER -- requirements
Module: arbi_requester

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of each data word.
REQ-002 The block SHALL have parameter DEPTH, default 4, FIFO entries, power of two, minimum 2.
REQ-003 The block SHALL have parameter MAX_WAIT, default 8, cycles of ungranted request before starve asserts, minimum 1.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  push wr_data into FIFO this cycle.
REQ-007 wr_data  input  DATA_WIDTH  word to queue.
REQ-008 full  output  1  FIFO holds DEPTH entries.
REQ-009 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 req  output  1  request to arbiter; connects to an arbiter req_0/req_1 input.
REQ-011 data_out  output  DATA_WIDTH  head word; connects to arbiter data_in0/data_in1.
REQ-012 grant  input  1  grant from arbiter; connects to grant_0/grant_1.
REQ-013 overflow  output  1  sticky, a push was dropped.
REQ-014 starve  output  1  req has been held MAX_WAIT or more cycles without grant.

Function
REQ-015 The block SHALL be a DEPTH-entry FIFO with read and write pointers wrapping modulo DEPTH.
REQ-016 A push SHALL occur on a rising edge with wr_en=1 and (full=0 or a pop in the same edge).
REQ-017 wr_en=1 with full=1 and no pop SHALL drop the word, leave FIFO unchanged, and set overflow on that edge.
REQ-018 A pop (transfer) SHALL occur on a rising edge where req=1 and grant=1; head entry removed, read pointer advanced.
REQ-019 grant=1 while req=0 SHALL be ignored: no pop, no state change.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including at full and at count=1.
REQ-021 FSM states: IDLE (req=0, FIFO empty) and REQ (req=1, FIFO non-empty); req is a registered state output.
REQ-022 IDLE->REQ on the edge where a push leaves count>=1; req rises 1 cycle after first wr_en.
REQ-023 REQ->IDLE on the edge where a pop leaves count=0 with no simultaneous push; otherwise stay in REQ (back-to-back transfers, req held high).
REQ-024 data_out SHALL equal the head entry whenever req=1, stable until the pop edge; data_out SHALL be 0 when req=0.
REQ-025 full = (count==DEPTH); count SHALL be registered and never exceed DEPTH.
REQ-026 wait counter SHALL increment each edge with req=1 and grant=0, saturate at MAX_WAIT, and clear to 0 on any pop or in IDLE.
REQ-027 starve SHALL equal (wait counter==MAX_WAIT); it deasserts on the edge after a pop.
REQ-028 overflow SHALL remain 1 until reset.
REQ-029 Word order SHALL be preserved: data_out words transferred equal wr_data words accepted, same order.

Reset
REQ-030 rst_in=0 SHALL asynchronously force: req=0, data_out=0, count=0, full=0, overflow=0, starve=0, pointers=0, wait counter=0, state IDLE.
REQ-031 Reset asserted mid-transfer SHALL discard all queued words; no request after release until a new push.
REQ-032 Release SHALL be synchronous-safe: first push accepted on the first rising edge with rst_in=1.

Verification
REQ-033 Reset, push 0xA5A5A5A5 once, grant=0 -> req=1 one cycle after push, data_out=0xA5A5A5A5 held, count=1.
REQ-034 Push 3 words, grant held high -> 3 transfers on consecutive edges in order, req drops after third, count=0.
REQ-035 DEPTH=4: push 5 words, no grant -> full=1, count=4, overflow=1, 5th word never appears on data_out.
REQ-036 full FIFO, wr_en=1 and req&grant same edge -> count stays 4, overflow stays 0, new word delivered last.
REQ-037 req=1, grant=0 for 8 cycles (MAX_WAIT=8) -> starve=1 after 8th edge; grant one cycle -> starve=0 next edge.
REQ-038 2 words queued, assert rst_in=0 between edges -> req=0, count=0 immediately; after release, req stays 0 with grant=1.
